// File: rtl/id_queue_stage.sv
// id_queue_stage: registered decode stage for the 16-bit RISC CPU.
// Decodes instructions, resolves branches against sampled flags and buffers entries in a small FIFO.
module id_queue_stage #(
    parameter int PC_W    = 16,
    parameter int DEPTH   = 2,
    parameter bit BR_EVAL = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_instr,
    input  logic [PC_W-1:0]            in_pc,
    input  logic                       flag_c,
    input  logic                       flag_z,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [19:0]                out_op,
    output logic [1:0]                 out_alu_sel,
    output logic [2:0]                 out_rd,
    output logic [2:0]                 out_rm,
    output logic [2:0]                 out_rn,
    output logic [7:0]                 out_imm8,
    output logic [10:0]                out_imm11,
    output logic [PC_W-1:0]            out_pc,
    output logic                       out_br_taken,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     out_count,
    output logic                       halted,
    input  logic                       resume
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [19:0]     dec_op;
    logic            dec_taken;
    logic            push, pop, full;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            halted_q, halted_d;
    logic [19:0]     op_mem    [DEPTH];
    logic [15:0]     instr_mem [DEPTH];
    logic [PC_W-1:0] pc_mem    [DEPTH];
    logic            tk_mem    [DEPTH];
    logic [15:0]     h_instr;

    always_comb begin
        dec_op = '0;
        case (in_instr[15:11])
            5'b00000: dec_op[4]  = 1'b1;
            5'b00001: dec_op[0]  = 1'b1;
            5'b00010: dec_op[1]  = 1'b1;
            5'b00011: dec_op[2]  = 1'b1;
            5'b00101: dec_op[3]  = 1'b1;
            5'b00110: dec_op[5]  = 1'b1;
            5'b00111: dec_op[6]  = 1'b1;
            5'b01000: dec_op[7]  = 1'b1;
            5'b01011: dec_op[8]  = 1'b1;
            5'b10000: dec_op[14] = 1'b1;
            5'b10001: dec_op[15] = 1'b1;
            5'b10010: dec_op[16] = 1'b1;
            5'b10011: dec_op[17] = 1'b1;
            5'b11100: begin
                dec_op[19] = in_instr[1:0] == 2'b00;
                dec_op[18] = in_instr[1:0] == 2'b01;
            end
            5'b11000, 5'b11001: begin
                case (in_instr[11:8])
                    4'h0:    dec_op[12] = 1'b1;
                    4'h1:    dec_op[11] = 1'b1;
                    4'h2:    dec_op[10] = 1'b1;
                    4'h3:    dec_op[9]  = 1'b1;
                    4'he:    dec_op[13] = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign dec_taken = BR_EVAL && ((dec_op[12] && flag_z) || (dec_op[11] && !flag_z) ||
                                   (dec_op[10] && flag_c) || (dec_op[9] && !flag_c) || dec_op[13]);

    assign full      = count_q == CW'(DEPTH);
    assign in_ready  = !full && !halted_q;
    assign out_valid = count_q != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        halted_d = (push && dec_op[18]) ? 1'b1 : resume ? 1'b0 : halted_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // Storage needs no reset: every head output is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q]    <= dec_op;
            instr_mem[wr_ptr_q] <= in_instr;
            pc_mem[wr_ptr_q]    <= in_pc;
            tk_mem[wr_ptr_q]    <= dec_taken;
        end
    end

    assign h_instr      = out_valid ? instr_mem[rd_ptr_q] : '0;
    assign out_op       = out_valid ? op_mem[rd_ptr_q] : '0;
    assign out_pc       = out_valid ? pc_mem[rd_ptr_q] : '0;
    assign out_br_taken = out_valid && tk_mem[rd_ptr_q];
    assign out_illegal  = out_valid && (op_mem[rd_ptr_q] == '0);
    assign out_alu_sel  = h_instr[1:0];
    assign out_rd       = h_instr[10:8];
    assign out_rm       = h_instr[7:5];
    assign out_rn       = h_instr[4:2];
    assign out_imm8     = h_instr[7:0];
    assign out_imm11    = h_instr[10:0];
    assign out_count    = count_q;
    assign halted       = halted_q;
endmodule

// File: tb/tb_id_queue_stage.sv
// tb_id_queue_stage: directed and random stimulus against a queue-based reference model.
module tb_id_queue_stage;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0, rst = 1'b1;
    logic          in_valid = 1'b0, out_ready = 1'b0, flag_c = 1'b0, flag_z = 1'b0, resume = 1'b0;
    logic [15:0]   in_instr = '0, in_pc = '0;
    logic          in_ready, out_valid, out_br_taken, out_illegal, halted;
    logic [19:0]   out_op;
    logic [1:0]    out_alu_sel;
    logic [2:0]    out_rd, out_rm, out_rn;
    logic [7:0]    out_imm8;
    logic [10:0]   out_imm11;
    logic [15:0]   out_pc;
    logic [CW-1:0] out_count;
    logic          b_in_ready, b_valid, b_tk, b_ill, b_halted;
    logic [19:0]   b_op;
    logic [1:0]    b_alu;
    logic [2:0]    b_rd, b_rm, b_rn;
    logic [7:0]    b_imm8;
    logic [10:0]   b_imm11;
    logic [15:0]   b_pc;
    logic [CW-1:0] b_count;

    always #5 clk = ~clk;

    id_queue_stage #(.PC_W(16), .DEPTH(DEPTH), .BR_EVAL(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flag_c(flag_c), .flag_z(flag_z), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_alu_sel(out_alu_sel), .out_rd(out_rd), .out_rm(out_rm), .out_rn(out_rn),
        .out_imm8(out_imm8), .out_imm11(out_imm11), .out_pc(out_pc), .out_br_taken(out_br_taken),
        .out_illegal(out_illegal), .out_count(out_count), .halted(halted), .resume(resume));

    id_queue_stage #(.PC_W(16), .DEPTH(DEPTH), .BR_EVAL(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flag_c(flag_c), .flag_z(flag_z), .out_valid(b_valid), .out_ready(out_ready),
        .out_op(b_op), .out_alu_sel(b_alu), .out_rd(b_rd), .out_rm(b_rm), .out_rn(b_rn),
        .out_imm8(b_imm8), .out_imm11(b_imm11), .out_pc(b_pc), .out_br_taken(b_tk),
        .out_illegal(b_ill), .out_count(b_count), .halted(b_halted), .resume(resume));

    typedef struct packed {
        logic [19:0] op;
        logic        tk;
        logic [15:0] ins;
        logic [15:0] pc;
    } ent_t;

    ent_t mq[$];
    logic m_halt = 1'b0;
    int   n_chk = 0, n_fail = 0;
    logic [15:0] pc_ctr = 16'h0100;
    logic [4:0]  opcs [16] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h05, 5'h06, 5'h07, 5'h08,
                              5'h0b, 5'h10, 5'h11, 5'h12, 5'h13, 5'h1c, 5'h18, 5'h19};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int op_idx(input logic [15:0] i);
        case (i[15:11])
            5'h00: return 4;
            5'h01: return 0;
            5'h02: return 1;
            5'h03: return 2;
            5'h05: return 3;
            5'h06: return 5;
            5'h07: return 6;
            5'h08: return 7;
            5'h0b: return 8;
            5'h10: return 14;
            5'h11: return 15;
            5'h12: return 16;
            5'h13: return 17;
            5'h1c: return (i[1:0] == 2'b00) ? 19 : (i[1:0] == 2'b01) ? 18 : -1;
            5'h18, 5'h19: begin
                case (i[11:8])
                    4'h0: return 12;
                    4'h1: return 11;
                    4'h2: return 10;
                    4'h3: return 9;
                    4'he: return 13;
                    default: return -1;
                endcase
            end
            default: return -1;
        endcase
    endfunction

    function automatic ent_t mk(input logic [15:0] ins, input logic [15:0] pc, input logic c, input logic z);
        ent_t e;
        int k = op_idx(ins);
        e.op  = (k < 0) ? 20'd0 : (20'd1 << k);
        e.tk  = (k == 12 && z) || (k == 11 && !z) || (k == 10 && c) || (k == 9 && !c) || k == 13;
        e.ins = ins;
        e.pc  = pc;
        return e;
    endfunction

    task automatic check_all();
        int n = mq.size();
        chk("valid", out_valid, n != 0);
        chk("count", out_count, n);
        chk("halted", halted, m_halt);
        chk("in_ready", in_ready, n < DEPTH && !m_halt);
        chk("br_eval0", b_tk, 0);
        if (n != 0) begin
            chk("op", out_op, mq[0].op);
            chk("alu_sel", out_alu_sel, mq[0].ins[1:0]);
            chk("rd", out_rd, mq[0].ins[10:8]);
            chk("rm", out_rm, mq[0].ins[7:5]);
            chk("rn", out_rn, mq[0].ins[4:2]);
            chk("imm8", out_imm8, mq[0].ins[7:0]);
            chk("imm11", out_imm11, mq[0].ins[10:0]);
            chk("pc", out_pc, mq[0].pc);
            chk("taken", out_br_taken, mq[0].tk);
            chk("illegal", out_illegal, mq[0].op == 0);
        end else begin
            chk("idle_fields", {out_op, out_imm11, out_imm8, out_rd, out_rm, out_rn, out_alu_sel,
                                out_br_taken, out_illegal}, 0);
            chk("idle_pc", out_pc, 0);
        end
    endtask

    task automatic step(input logic iv, input logic [15:0] ins, input logic c, input logic z,
                        input logic ordy, input logic res);
        logic m_push, m_pop;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc_ctr;
        flag_c    = c;
        flag_z    = z;
        out_ready = ordy;
        resume    = res;
        m_push = iv && mq.size() < DEPTH && !m_halt;
        m_pop  = mq.size() > 0 && ordy;
        @(posedge clk);
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
            mq.push_back(mk(ins, pc_ctr, c, z));
            pc_ctr = pc_ctr + 16'd2;
        end
        if (m_push && op_idx(ins) == 18) m_halt = 1'b1;
        else if (res) m_halt = 1'b0;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", out_count, 0);
        chk("rst_halted", halted, 0);
        chk("rst_op", out_op, 0);
        rst = 1'b0;
        @(negedge clk);
        check_all();

        step(1, 16'h0F12, 0, 0, 1, 0);
        chk("lhi_op", out_op, 20'h00001);
        chk("lhi_rd", out_rd, 7);
        chk("lhi_imm8", out_imm8, 8'h12);
        chk("lhi_pc", out_pc, 16'h0100);

        step(1, 16'hC0AA, 0, 1, 1, 0);
        step(1, 16'hC1BB, 0, 1, 0, 0);
        chk("beq_taken", out_br_taken, 1);
        step(0, 16'h0000, 0, 0, 1, 0);
        chk("bne_taken", out_br_taken, 0);
        step(0, 16'h0000, 0, 0, 1, 0);

        for (int i = 0; i <= DEPTH; i++) step(1, {opcs[i], 11'($urandom)}, 0, 0, 0, 0);
        chk("full_ready", in_ready, 0);
        chk("full_count", out_count, DEPTH);
        for (int i = 0; i < 7; i++) step(1, {opcs[i + 3], 11'($urandom)}, 0, 0, 1, 0);
        repeat (DEPTH) step(0, 16'h0000, 0, 0, 1, 0);

        step(1, 16'hE001, 0, 0, 0, 0);
        chk("hlt_halted", halted, 1);
        step(1, 16'h0000, 0, 0, 0, 0);
        chk("hlt_block", out_count, 1);
        chk("hlt_op", out_op, 20'h40000);
        step(0, 16'h0000, 0, 0, 1, 0);
        step(0, 16'h0000, 0, 0, 0, 1);
        chk("resume_ready", in_ready, 1);
        step(1, 16'h0000, 0, 0, 1, 0);
        step(0, 16'h0000, 0, 0, 1, 1);
        step(1, 16'hE001, 0, 0, 1, 1);
        chk("hlt_vs_resume", halted, 1);
        step(0, 16'h0000, 0, 0, 1, 1);

        step(1, 16'hE002, 0, 0, 0, 0);
        step(1, 16'h6800, 0, 0, 0, 0);
        chk("ill_flag", out_illegal, 1);
        step(0, 16'h0000, 0, 0, 1, 0);
        chk("ill_flag2", out_illegal, 1);
        step(0, 16'h0000, 0, 0, 1, 0);

        for (int i = 0; i < 2000; i++) begin
            logic [15:0] w = 16'($urandom);
            if ($urandom_range(0, 1) == 1) w[15:11] = opcs[$urandom_range(0, 15)];
            step($urandom_range(0, 3) != 0, w, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
        end

        step(0, 16'h0000, 0, 0, 1, 1);
        step(0, 16'h0000, 0, 0, 1, 0);
        step(1, 16'h0004, 0, 0, 0, 0);
        step(1, 16'hE001, 0, 0, 0, 0);
        chk("pre_rst_count", out_count, 2);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_count", out_count, 0);
        chk("arst_halted", halted, 0);
        chk("arst_op", out_op, 0);
        mq.delete();
        m_halt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all();
        step(1, 16'h0F12, 0, 0, 1, 0);
        step(0, 16'h0000, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
